ex_muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide engine in the execute stage, directly downstream of the ID/EX pipeline register. It consumes the EX-side operands and funct3 of an M-extension instruction and computes the result over 32 iterations. While it works it raises `stall`, which drives the ID/EX register's `dontUpdate` and freezes the upstream stages. It presents the result for exactly one cycle so the EX/MEM register can capture it.

---
 rtl/ex_muldiv_unit.sv | 177 +++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide engine for the execute stage.
// Shift-add multiply and restoring divide on operand magnitudes, one bit per cycle,
// with the sign applied and the result selected when the last iteration completes.
module ex_muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] lhs,
  input  logic [WIDTH-1:0] rhs,
  output logic             stall,
  output logic             resultValid,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned     CntW    = $clog2(WIDTH) + 1;
  localparam logic [CntW-1:0] CntInit = CntW'(WIDTH);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StRun, StDone} stateT;

  stateT             stateQ, stateD;
  logic [CntW-1:0]   cntQ, cntD;
  logic [2:0]        opQ, opD;
  logic [WIDTH-1:0]  lhsMagQ, lhsMagD;
  logic [WIDTH-1:0]  rhsMagQ, rhsMagD;
  logic              negQ, negD;
  logic              specialQ, specialD;
  logic [WIDTH-1:0]  specialValQ, specialValD;
  // hiQ/loQ hold {product hi, multiplier/product lo} or {remainder, dividend/quotient}
  logic [WIDTH-1:0]  hiQ, hiD;
  logic [WIDTH-1:0]  loQ, loD;
  logic [WIDTH-1:0]  resultQ, resultD;

  // Start-cycle operand decode
  logic             lhsSigned, rhsSigned, lhsNeg, rhsNeg, isRem, divZero, divOvf;
  logic [WIDTH-1:0] lhsMag, rhsMag;

  // Decode signedness, magnitudes and special cases from the live inputs
  always_comb begin
    lhsSigned = (funct3 == 3'b001) | (funct3 == 3'b010) | (funct3 == 3'b100) |
                (funct3 == 3'b110);
    rhsSigned = (funct3 == 3'b001) | (funct3 == 3'b100) | (funct3 == 3'b110);
    lhsNeg    = lhsSigned & lhs[WIDTH-1];
    rhsNeg    = rhsSigned & rhs[WIDTH-1];
    lhsMag    = lhsNeg ? (~lhs + 1'b1) : lhs;
    rhsMag    = rhsNeg ? (~rhs + 1'b1) : rhs;
    isRem     = funct3[2] & funct3[1];
    divZero   = funct3[2] & (rhs == '0);
    divOvf    = funct3[2] & ~funct3[0] & (lhs == MinNeg) & (rhs == '1);
  end

  // One iteration step and final result shaping
  logic [WIDTH:0]     mulSum, divShift, divDiff;
  logic               divFits;
  logic [WIDTH-1:0]   iterHi, iterLo, divVal, divSigned, finalVal;
  logic [2*WIDTH-1:0] prod, prodSigned;

  // Compute the next iteration and the value that would be presented in DONE
  always_comb begin
    mulSum   = {1'b0, hiQ} + (loQ[0] ? {1'b0, lhsMagQ} : '0);
    divShift = {hiQ, loQ[WIDTH-1]};
    divDiff  = divShift - {1'b0, rhsMagQ};
    divFits  = ~divDiff[WIDTH];
    if (opQ[2]) begin
      iterHi = divFits ? divDiff[WIDTH-1:0] : divShift[WIDTH-1:0];
      iterLo = {loQ[WIDTH-2:0], divFits};
    end else begin
      iterHi = mulSum[WIDTH:1];
      iterLo = {mulSum[0], loQ[WIDTH-1:1]};
    end
    prod       = {iterHi, iterLo};
    prodSigned = negQ ? (~prod + 1'b1) : prod;
    divVal     = opQ[1] ? iterHi : iterLo;
    divSigned  = negQ ? (~divVal + 1'b1) : divVal;
    if (specialQ) begin
      finalVal = specialValQ;
    end else if (opQ[2]) begin
      finalVal = divSigned;
    end else if (opQ[1:0] == 2'b00) begin
      finalVal = prodSigned[WIDTH-1:0];
    end else begin
      finalVal = prodSigned[2*WIDTH-1:WIDTH];
    end
  end

  // Next-state logic: latch on start, iterate in RUN, present in DONE
  always_comb begin
    stateD      = stateQ;
    cntD        = cntQ;
    opD         = opQ;
    lhsMagD     = lhsMagQ;
    rhsMagD     = rhsMagQ;
    negD        = negQ;
    specialD    = specialQ;
    specialValD = specialValQ;
    hiD         = hiQ;
    loD         = loQ;
    resultD     = resultQ;
    unique case (stateQ)
      StIdle: begin
        if (start && !flush) begin
          stateD      = StRun;
          cntD        = CntInit;
          opD         = funct3;
          lhsMagD     = lhsMag;
          rhsMagD     = rhsMag;
          negD        = isRem ? lhsNeg : (lhsNeg ^ rhsNeg);
          specialD    = divZero | divOvf;
          // Divide by zero wins over overflow (rhs cannot be both 0 and -1)
          specialValD = divZero ? (isRem ? lhs : '1) : (isRem ? '0 : MinNeg);
          hiD         = '0;
          loD         = funct3[2] ? lhsMag : rhsMag;
        end
      end
      StRun: begin
        if (flush) begin
          stateD = StIdle;
        end else begin
          hiD  = iterHi;
          loD  = iterLo;
          cntD = cntQ - CntOne;
          if (cntQ == CntOne) begin
            stateD  = StDone;
            resultD = finalVal;
          end
        end
      end
      StDone: begin
        // Same instruction is still in EX, so start is ignored here
        stateD = StIdle;
      end
      default: stateD = StIdle;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateQ      <= StIdle;
      cntQ        <= '0;
      opQ         <= '0;
      lhsMagQ     <= '0;
      rhsMagQ     <= '0;
      negQ        <= 1'b0;
      specialQ    <= 1'b0;
      specialValQ <= '0;
      hiQ         <= '0;
      loQ         <= '0;
      resultQ     <= '0;
    end else begin
      stateQ      <= stateD;
      cntQ        <= cntD;
      opQ         <= opD;
      lhsMagQ     <= lhsMagD;
      rhsMagQ     <= rhsMagD;
      negQ        <= negD;
      specialQ    <= specialD;
      specialValQ <= specialValD;
      hiQ         <= hiD;
      loQ         <= loD;
      resultQ     <= resultD;
    end
  end

  // Outputs: stall must drop asynchronously while reset is held
  always_comb begin
    stall       = rst & (((stateQ == StIdle) & start & ~flush) | (stateQ == StRun));
    resultValid = (stateQ == StDone);
    result      = resultQ;
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed-vector bench for ex_muldiv_unit with hand-computed expected results.
module tb_ex_muldiv_unit;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] lhs;
  logic [31:0] rhs;
  logic        stall;
  logic        resultValid;
  logic [31:0] result;

  int checks;
  int failures;

  ex_muldiv_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .start      (start),
    .funct3     (funct3),
    .lhs        (lhs),
    .rhs        (rhs),
    .stall      (stall),
    .resultValid(resultValid),
    .result     (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called in cycle 0 (inputs already driven); stops at the DONE cycle.
  task automatic waitResult(input string tag, input logic [31:0] exp);
    int n;
    n = 0;
    #1;
    while (stall === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    checkEq({tag, "_stallCycles"}, n, 33);
    checkEq({tag, "_valid"}, {31'd0, resultValid}, 32'd1);
    checkEq({tag, "_result"}, result, exp);
  endtask

  task automatic finishOp(input string tag, input logic [31:0] exp);
    waitResult(tag, exp);
    start = 1'b0;
    @(negedge clk);
    checkEq({tag, "_pulseEnd"}, {30'd0, resultValid, stall}, 32'd0);
  endtask

  task automatic doOp(input string tag, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp);
    @(negedge clk);
    funct3 = f3;
    lhs    = a;
    rhs    = b;
    start  = 1'b1;
    finishOp(tag, exp);
  endtask

  task automatic countPulses(input string tag, input int cycles);
    int pulses;
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (resultValid) pulses++;
    end
    checkEq(tag, pulses, 0);
  endtask

  initial begin
    int gap;
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    flush    = 1'b0;
    start    = 1'b1;
    funct3   = 3'b001;
    lhs      = 32'hFFFF_FFFF;
    rhs      = 32'h0000_0002;

    // Reset held with start high
    repeat (3) @(negedge clk);
    checkEq("rstStall", {31'd0, stall}, 32'd0);
    checkEq("rstValid", {31'd0, resultValid}, 32'd0);
    checkEq("rstResult", result, 32'd0);
    rst = 1'b1;
    #1;
    checkEq("rstReleaseStall", {31'd0, stall}, 32'd1);
    // MULH -1 * 2 proceeds from the reset release
    finishOp("mulh", 32'hFFFF_FFFF);

    doOp("mul",    3'b000, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE);
    doOp("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    doOp("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    doOp("div",    3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD);
    doOp("rem",    3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF);
    doOp("divu",   3'b101, 32'h0000_0007, 32'h0000_0002, 32'h0000_0003);
    doOp("divNN",  3'b100, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'h0000_0002);
    doOp("remNN",  3'b110, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE);
    doOp("divZero",  3'b100, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF);
    doOp("remuZero", 3'b111, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234);
    doOp("divOvf",   3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    doOp("remOvf",   3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);

    // Flush at RUN cycle 10
    @(negedge clk);
    funct3 = 3'b101;
    lhs    = 32'd100;
    rhs    = 32'd7;
    start  = 1'b1;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    start = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    checkEq("flushStall", {31'd0, stall}, 32'd0);
    countPulses("flushNoPulse", 40);
    doOp("remuAfterFlush", 3'b111, 32'd100, 32'd7, 32'd2);

    // Reset pulled at RUN cycle 20
    @(negedge clk);
    funct3 = 3'b000;
    lhs    = 32'd3;
    rhs    = 32'd5;
    start  = 1'b1;
    repeat (20) @(negedge clk);
    rst = 1'b0;
    #1;
    checkEq("midRstStall", {31'd0, stall}, 32'd0);
    checkEq("midRstResult", result, 32'd0);
    @(negedge clk);
    start = 1'b0;
    rst   = 1'b1;
    @(negedge clk);
    checkEq("midRstIdle", {31'd0, stall}, 32'd0);
    countPulses("midRstNoPulse", 40);
    doOp("mulAfterRst", 3'b000, 32'd3, 32'd5, 32'd15);

    // Back-to-back MULHU with start held through DONE
    @(negedge clk);
    funct3 = 3'b011;
    lhs    = 32'hFFFF_FFFF;
    rhs    = 32'hFFFF_FFFF;
    start  = 1'b1;
    waitResult("b2bFirst", 32'hFFFF_FFFE);
    lhs = 32'h8000_0000;
    rhs = 32'h0000_0004;
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
    end while (!resultValid && gap < 100);
    checkEq("b2bGap", gap, 34);
    checkEq("b2bSecond", result, 32'h0000_0002);
    start = 1'b0;
    countPulses("b2bNoRetrigger", 40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
